// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned ALU_ARB_NREQ = 2;
  localparam int unsigned REQ_INT      = 0;
  localparam int unsigned REQ_FPU      = 1;
  localparam int unsigned FUNC_W       = 3;
  localparam int unsigned FLAG_W       = 3;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_ADD  = 3'b000,
    FUNC_SLL  = 3'b001,
    FUNC_SLT  = 3'b010,
    FUNC_SLTU = 3'b011,
    FUNC_XOR  = 3'b100,
    FUNC_SR   = 3'b101,
    FUNC_OR   = 3'b110,
    FUNC_AND  = 3'b111
  } alu_func_e;

  typedef struct packed {
    logic eq;
    logic ls;
    logic lu;
  } alu_flags_t;

endpackage

// File: rtl/alu_arb_rsp_slot.sv
// One-entry response buffer: capture wins over drain, so a slot can take one op per cycle.
module alu_arb_rsp_slot #(
  parameter int unsigned W = 67
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         capture,
  input  logic [W-1:0] data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      q     <= data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the integer execute stage and the FPU/AGU path.
// Define ALU_ARB_RR_EN for round-robin on ties; otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ALU_ARB_NREQ-1:0] req_valid,
  output logic [ALU_ARB_NREQ-1:0] req_ready,
  input  logic [XLEN-1:0]         req_a0,
  input  logic [XLEN-1:0]         req_b0,
  input  logic [XLEN-1:0]         req_a1,
  input  logic [XLEN-1:0]         req_b1,
  input  logic [FUNC_W-1:0]       req_func0,
  input  logic [FUNC_W-1:0]       req_func1,
  input  logic                    req_sub_sra0,
  input  logic                    req_sub_sra1,
  output logic [XLEN-1:0]         alu_a,
  output logic [XLEN-1:0]         alu_b,
  output logic [FUNC_W-1:0]       alu_func,
  output logic                    alu_sub_sra,
  input  logic [XLEN-1:0]         alu_s,
  input  logic                    alu_eq,
  input  logic                    alu_ls,
  input  logic                    alu_lu,
  output logic [ALU_ARB_NREQ-1:0] rsp_valid,
  input  logic [ALU_ARB_NREQ-1:0] rsp_ready,
  output logic [XLEN-1:0]         rsp_s0,
  output logic [XLEN-1:0]         rsp_s1,
  output logic [FLAG_W-1:0]       rsp_flags0,
  output logic [FLAG_W-1:0]       rsp_flags1
);

  localparam int unsigned SLOT_W = XLEN + FLAG_W;

  logic [ALU_ARB_NREQ-1:0] free;
  logic [ALU_ARB_NREQ-1:0] elig;
  logic [ALU_ARB_NREQ-1:0] grant;
  logic                    prio;
  logic                    valid0;
  logic                    valid1;
  alu_flags_t              flags;
  logic [SLOT_W-1:0]       slot_data;

  // A slot draining this cycle can accept a new capture; no grants while in reset.
  assign free = ~rsp_valid | rsp_ready;
  assign elig = req_valid & free & {ALU_ARB_NREQ{rst_n}};

  always_comb begin
    grant = '0;
    if (&elig) begin
      grant[REQ_FPU] = prio;
      grant[REQ_INT] = ~prio;
    end else begin
      grant = elig;
    end
  end

  assign req_ready = grant;

`ifdef ALU_ARB_RR_EN
  // Tie-break pointer: after serving requester i, the other one wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (|grant) begin
      prio <= grant[REQ_INT];
    end
  end
`else
  assign prio = 1'b0;
`endif

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_func    = FUNC_ADD;
    alu_sub_sra = 1'b0;
    if (grant[REQ_INT]) begin
      alu_a       = req_a0;
      alu_b       = req_b0;
      alu_func    = req_func0;
      alu_sub_sra = req_sub_sra0;
    end else if (grant[REQ_FPU]) begin
      alu_a       = req_a1;
      alu_b       = req_b1;
      alu_func    = req_func1;
      alu_sub_sra = req_sub_sra1;
    end
  end

  assign flags     = '{eq: alu_eq, ls: alu_ls, lu: alu_lu};
  assign slot_data = {alu_s, flags};

  alu_arb_rsp_slot #(.W(SLOT_W)) u_slot0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (grant[REQ_INT]),
    .data    (slot_data),
    .ready   (rsp_ready[REQ_INT]),
    .valid   (valid0),
    .q       ({rsp_s0, rsp_flags0})
  );

  alu_arb_rsp_slot #(.W(SLOT_W)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (grant[REQ_FPU]),
    .data    (slot_data),
    .ready   (rsp_ready[REQ_FPU]),
    .valid   (valid1),
    .q       ({rsp_s1, rsp_flags1})
  );

  assign rsp_valid = {valid1, valid0};

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter; follows ALU_ARB_RR_EN to pick the tie policy model.
module tb_alu_arbiter;

  localparam int unsigned XLEN = 64;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [XLEN-1:0] op_a [2];
  logic [XLEN-1:0] op_b [2];
  logic [2:0]      op_f [2];
  logic            op_s [2];
  logic [XLEN-1:0] alu_a, alu_b, alu_s;
  logic [2:0]      alu_func;
  logic            alu_sub_sra, alu_eq, alu_ls, alu_lu;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [XLEN-1:0] rsp_s0, rsp_s1;
  logic [2:0]      rsp_flags0, rsp_flags1;

  int n_vec;
  int n_err;

  logic [1:0]      m_valid;
  logic            m_prio;
  logic [1:0]      last_grant;
  logic [XLEN+2:0] q0 [$];
  logic [XLEN+2:0] q1 [$];

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a0       (op_a[0]),
    .req_b0       (op_b[0]),
    .req_a1       (op_a[1]),
    .req_b1       (op_b[1]),
    .req_func0    (op_f[0]),
    .req_func1    (op_f[1]),
    .req_sub_sra0 (op_s[0]),
    .req_sub_sra1 (op_s[1]),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_func     (alu_func),
    .alu_sub_sra  (alu_sub_sra),
    .alu_s        (alu_s),
    .alu_eq       (alu_eq),
    .alu_ls       (alu_ls),
    .alu_lu       (alu_lu),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_s0       (rsp_s0),
    .rsp_s1       (rsp_s1),
    .rsp_flags0   (rsp_flags0),
    .rsp_flags1   (rsp_flags1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: result followed by {eq, ls, lu}.
  function automatic logic [XLEN+2:0] ref_alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                               input logic [2:0] f, input logic s);
    logic [XLEN-1:0] r;
    case (f)
      3'd0:    r = s ? a - b : a + b;
      3'd1:    r = a << b[5:0];
      3'd2:    r = {63'd0, $signed(a) < $signed(b)};
      3'd3:    r = {63'd0, a < b};
      3'd4:    r = a ^ b;
      3'd5:    r = s ? XLEN'($signed(a) >>> b[5:0]) : a >> b[5:0];
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return {r, a == b, $signed(a) < $signed(b), a < b};
  endfunction

  always_comb {alu_s, alu_eq, alu_ls, alu_lu} = ref_alu(alu_a, alu_b, alu_func, alu_sub_sra);

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [2:0] f, input logic s);
    op_a[i] = a;
    op_b[i] = b;
    op_f[i] = f;
    op_s[i] = s;
  endtask

  // One clock: drive, check grant and ALU drive mid-cycle, then check captured responses.
  task automatic cycle(input logic [1:0] v, input logic [1:0] rr);
    logic [1:0]      elig;
    logic [1:0]      eg;
    logic [XLEN+2:0] e;
    int              g;
    req_valid = v;
    rsp_ready = rr;
    @(negedge clk);
    elig = v & (~m_valid | rr);
    if (elig == 2'b11) eg = m_prio ? 2'b10 : 2'b01;
    else eg = elig;
    last_grant = req_ready;
    check("req_ready", 64'(req_ready), 64'(eg));
    if (eg != 2'b00) begin
      g = eg[1] ? 1 : 0;
      check("alu_a", alu_a, op_a[g]);
      check("alu_b", alu_b, op_b[g]);
      check("alu_func", 64'(alu_func), 64'(op_f[g]));
      check("alu_sub_sra", 64'(alu_sub_sra), 64'(op_s[g]));
      if (g == 0) q0.push_back(ref_alu(op_a[0], op_b[0], op_f[0], op_s[0]));
      else        q1.push_back(ref_alu(op_a[1], op_b[1], op_f[1], op_s[1]));
    end else begin
      check("alu_idle", {alu_a[XLEN-5:0], alu_func, alu_sub_sra}, 64'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (eg[i]) m_valid[i] = 1'b1;
      else if (rr[i]) m_valid[i] = 1'b0;
    end
`ifdef ALU_ARB_RR_EN
    if (eg != 2'b00) m_prio = eg[0];
`endif
    check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    if (eg[0]) begin
      e = q0.pop_front();
      check("rsp_s0", rsp_s0, e[XLEN+2:3]);
      check("rsp_flags0", 64'(rsp_flags0), 64'(e[2:0]));
    end
    if (eg[1]) begin
      e = q1.pop_front();
      check("rsp_s1", rsp_s1, e[XLEN+2:3]);
      check("rsp_flags1", 64'(rsp_flags1), 64'(e[2:0]));
    end
  endtask

  initial begin
    logic [7:0] seq;
    n_vec = 0;
    n_err = 0;
    m_valid = 2'b00;
    m_prio = 1'b0;
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    set_op(0, 64'd3, 64'd4, 3'd0, 1'b0);
    set_op(1, 64'd9, 64'd1, 3'd0, 1'b0);

    // Reset state, including no grant while held in reset.
    #2;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_alu_a", alu_a, 64'd0);
    check("rst_rsp_s0", rsp_s0, 64'd0);
    check("rst_rsp_s1", rsp_s1, 64'd0);
    check("rst_flags", 64'({rsp_flags0, rsp_flags1}), 64'd0);
    req_valid = 2'b00;
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add on requester 0.
    set_op(0, 64'd5, 64'd7, 3'b000, 1'b0);
    cycle(2'b01, 2'b00);
    check("add_result", rsp_s0, 64'd12);

    // Signed compare on requester 1; slot 0 drains.
    set_op(1, '1, 64'd1, 3'b010, 1'b1);
    cycle(2'b10, 2'b01);
    check("slt_result", rsp_s1, 64'd1);
    check("slt_flags", 64'(rsp_flags1), 64'(3'b010));

    // Both continuously eligible.
    set_op(0, 64'd100, 64'd3, 3'b101, 1'b0);
    set_op(1, 64'hF0, 64'h3C, 3'b100, 1'b0);
    seq = '0;
    for (int k = 0; k < 4; k++) begin
      cycle(2'b11, 2'b11);
      seq = {last_grant, seq[7:2]};
    end
`ifdef ALU_ARB_RR_EN
    check("tie_sequence", 64'(seq), 64'(8'b10_01_10_01));
`else
    check("tie_sequence", 64'(seq), 64'(8'b01_01_01_01));
`endif

    // Backpressure on slot 0: requester 1 takes every grant until release.
    set_op(0, 64'd8, 64'd2, 3'b000, 1'b1);
    set_op(1, 64'd1, 64'd4, 3'b001, 1'b0);
    cycle(2'b01, 2'b10);
    for (int k = 0; k < 3; k++) begin
      set_op(1, 64'(k + 1), 64'(k), 3'b110, 1'b0);
      cycle(2'b11, 2'b10);
      check("bp_grant1", 64'(last_grant), 64'd2);
    end
    cycle(2'b11, 2'b11);
    check("bp_release", 64'(last_grant), 64'd1);
    cycle(2'b00, 2'b11);

    // Back-to-back on slot 0.
    set_op(0, 64'd1, 64'd1, 3'b000, 1'b0);
    cycle(2'b01, 2'b11);
    check("b2b_first", rsp_s0, 64'd2);
    set_op(0, 64'd2, 64'd2, 3'b000, 1'b0);
    cycle(2'b01, 2'b11);
    check("b2b_second", rsp_s0, 64'd4);
    check("b2b_valid", 64'(rsp_valid[0]), 64'd1);

    // Mixed traffic across all functions.
    for (int k = 0; k < 10; k++) begin
      set_op(0, {$urandom, $urandom}, 64'($urandom_range(0, 70)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      set_op(1, {$urandom, $urandom}, (k % 3 == 0) ? op_a[0] : 64'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    cycle(2'b00, 2'b11);

    // Reset mid-operation with both slots full and pointer favouring requester 1.
    set_op(1, 64'd6, 64'd6, 3'b000, 1'b1);
    cycle(2'b10, 2'b00);
    set_op(0, 64'd7, 64'd6, 3'b111, 1'b0);
    cycle(2'b01, 2'b00);
    check("pre_rst_valid", 64'(rsp_valid), 64'd3);
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd0);
    check("arst_alu_a", alu_a, 64'd0);
    @(posedge clk);
    #1;
    check("arst_hold_ready", 64'(req_ready), 64'd0);
    m_valid = 2'b00;
    m_prio = 1'b0;
    q0.delete();
    q1.delete();
    #2 rst_n = 1'b1;
    cycle(2'b11, 2'b11);
    check("post_rst_tie", 64'(last_grant), 64'd1);
    cycle(2'b00, 2'b11);

    check("sb_empty", 64'(q0.size() + q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequential arbiter that shares the single integer ALU between two requesters: requester 0 is the integer execute stage and requester 1 is the FPU/address-generation path. Each cycle it grants at most one valid request and drives the external ALU's `a`, `b`, `func` and `sub_sra` inputs from that request. It captures the ALU result and the `eq`/`ls`/`lu` flags into a per-requester one-entry response buffer, returned through a valid/ready handshake. It sits between the requesters and the ALU instance; the ALU itself stays purely combinational.

## Interface
Parameters:
- XLEN, 64, operand/result width; must equal the ALU width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester grant; a transfer happens when valid & ready
- req_a0, req_b0 / req_a1, req_b1  in  XLEN each  operands of requester 0 / 1
- req_func0 / req_func1  in  3 each  ALU function code
- req_sub_sra0 / req_sub_sra1  in  1 each  subtract / arithmetic-shift select
- alu_a, alu_b  out  XLEN each  to the ALU operand inputs
- alu_func  out  3  to the ALU func input
- alu_sub_sra  out  1  to the ALU sub_sra input
- alu_s  in  XLEN  ALU result
- alu_eq, alu_ls, alu_lu  in  1 each  ALU comparator flags
- rsp_valid  out  2  per-requester response valid
- rsp_ready  in  2  per-requester response accept
- rsp_s0 / rsp_s1  out  XLEN each  captured result
- rsp_flags0 / rsp_flags1  out  3 each  captured {eq, ls, lu}

## Operation
- Slot free for requester i: `free_i = !rsp_valid[i] | rsp_ready[i]`.
- Eligible: `req_valid[i] & free_i`.
- Grant (combinational):
  - If only one requester is eligible, it wins.
  - If both are eligible, the requester selected by the priority pointer `prio` (1 bit) wins.
  - `req_ready` is one-hot or zero.
- ALU drive:
  - With a grant, the `alu_*` outputs carry the granted requester's operands, func and sub_sra.
  - With no grant, all `alu_*` outputs are 0 (func 3'b000).
- Capture: on the edge where requester i is granted, `rsp_s_i <= alu_s`, `rsp_flags_i <= {alu_eq, alu_ls, alu_lu}`, `rsp_valid[i] <= 1`.
- Drain: `rsp_valid[i] & rsp_ready[i]` with no new capture for i clears `rsp_valid[i]`.
- Simultaneous drain and capture on the same slot:
  - The data is overwritten.
  - `rsp_valid` stays 1.
  - The slot sustains one op per cycle.
- Pointer update: after a grant to requester i, `prio <= ~i`. With no grant, `prio` holds.
- Requester rule: once `req_valid` is asserted, the requester holds it and its operands stable until `req_ready`. The arbiter does not check this rule.
- Comparator flags are meaningful only when the requester set sub_sra = 1. They are passed through unmodified.

## Timing
- Request-to-response latency is 1 cycle: a grant in cycle N gives `rsp_valid` in cycle N+1.
- Throughput is one ALU op per cycle in total.
- With both requesters continuously eligible, grants alternate 0,1,0,1.
- Reset values:
  - `prio = 0` (requester 0 first).
  - `rsp_valid = 2'b00`.
  - `rsp_s0`, `rsp_s1`, `rsp_flags0`, `rsp_flags1` = 0.
  - `req_ready = 0`; `alu_*` outputs = 0 (they follow from the reset state).
- Reset asserted mid-operation:
  - All buffered responses are discarded immediately (asynchronous).
  - No grant is issued while `rst_n` is low.
- Backpressure: a requester whose response is stalled (`rsp_valid=1`, `rsp_ready=0`) is not eligible. The other requester then receives every grant.

## Configuration
- `ALU_ARB_RR_EN` defined:
  - Round-robin policy as described above.
- `ALU_ARB_RR_EN` undefined:
  - Fixed priority: requester 0 always wins when both are eligible.
  - The `prio` register is not implemented.
  - Requester 1 can starve.

## Structure
- Shared package `alu_arb_pkg` holds:
  - The ALU func encodings: ADD 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
  - The requester count `ALU_ARB_NREQ = 2`.
  - The requester index constants `REQ_INT = 0`, `REQ_FPU = 1`.
- Sub-module `alu_arb_rsp_slot` is the one-entry response buffer (capture/drain logic, XLEN+3 data bits). It is instantiated once per requester.

## Test plan
- Single op, requester 0, add: a=5, b=7, func=000, sub_sra=0. Expected: `req_ready[0]` in the same cycle; next cycle `rsp_valid[0]=1`, `rsp_s0=12`.
- Compare, requester 1: a=-1, b=1, func=010, sub_sra=1. Expected: `rsp_s1=1`, `rsp_flags1=3'b010` (eq=0, ls=1, lu=0).
- Both requesters valid continuously with `rsp_ready=2'b11`:
  - With `ALU_ARB_RR_EN`: grants 0,1,0,1 over 4 cycles.
  - Without it: grants 0,0,0,0.
- Backpressure: `rsp_valid[0]=1`, `rsp_ready[0]=0`, both requesting. Expected: requester 1 granted every cycle. Release `rsp_ready[0]`: requester 0 is granted in that same cycle.
- Back-to-back on one slot: requester 0 issues a=1,b=1 then a=2,b=2 with `rsp_ready[0]=1`. Expected: responses 2 then 4 on consecutive cycles, `rsp_valid[0]` held at 1.
- Reset mid-operation: `rsp_valid=2'b11`, pull `rst_n` low between edges. Expected: `rsp_valid=0` and `req_ready=0` immediately; after release, the first tie is granted to requester 0.
